// File: rtl/alarm_time_keeper.sv
// Alarm time register bank plus arming FSM: holds the programmed alarm time,
// compares it with the running clock and rings until dismiss, timeout or disable.
module alarm_time_keeper #(
  parameter int RING_TICKS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       upsec,
  input  logic       upmin,
  input  logic       uphour,
  input  logic       alarm_en,
  input  logic       dismiss,
  input  logic       tick,
  input  logic [5:0] cur_sec,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hour,
  output logic [5:0] alarm_sec,
  output logic [5:0] alarm_min,
  output logic [4:0] alarm_hour,
  output logic       ringing,
  output logic [1:0] fsm_state
);

  localparam int CW = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(RING_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RING    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] ring_cnt;
  logic          match;
  logic          timeout;
  logic          edit_en;
  logic          cnt_clear;
  logic          cnt_inc;

  assign match   = (cur_sec == alarm_sec) && (cur_min == alarm_min) && (cur_hour == alarm_hour);
  assign timeout = tick && (ring_cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a low enable overrides every other condition
  always_comb begin
    state_next = state;
    if (!alarm_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ARMED;
        ARMED:   if (match) state_next = RING;
        RING:    if (dismiss || timeout) state_next = HOLDOFF;
        HOLDOFF: if (!match) state_next = ARMED;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    edit_en   = (state != RING);
    cnt_clear = (state != RING) && (state_next == RING);
    cnt_inc   = (state == RING) && tick;
    fsm_state = state;
  end

  // ringing is registered from the next state so it tracks fsm_state exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ringing <= 1'b0;
    else       ringing <= (state_next == RING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          ring_cnt <= '0;
    else if (cnt_clear) ring_cnt <= '0;
    else if (cnt_inc)   ring_cnt <= ring_cnt + 1'b1;
  end

  // Fields wrap independently; no carry between them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_sec  <= 6'd0;
      alarm_min  <= 6'd0;
      alarm_hour <= 5'd0;
    end else if (edit_en) begin
      if (upsec)  alarm_sec  <= (alarm_sec  == 6'd59) ? 6'd0 : alarm_sec  + 6'd1;
      if (upmin)  alarm_min  <= (alarm_min  == 6'd59) ? 6'd0 : alarm_min  + 6'd1;
      if (uphour) alarm_hour <= (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
    end
  end

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Directed bench for alarm_time_keeper (RING_TICKS=3): field wrap, trigger,
// dismiss, timeout, disable, edit lockout, async reset and edit-induced trigger.
module tb_alarm_time_keeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       upsec, upmin, uphour, alarm_en, dismiss, tick;
  logic [5:0] cur_sec, cur_min;
  logic [4:0] cur_hour;
  logic [5:0] alarm_sec, alarm_min;
  logic [4:0] alarm_hour;
  logic       ringing;
  logic [1:0] fsm_state;

  int tests = 0;
  int fails = 0;

  alarm_time_keeper #(.RING_TICKS(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .upsec      (upsec),
    .upmin      (upmin),
    .uphour     (uphour),
    .alarm_en   (alarm_en),
    .dismiss    (dismiss),
    .tick       (tick),
    .cur_sec    (cur_sec),
    .cur_min    (cur_min),
    .cur_hour   (cur_hour),
    .alarm_sec  (alarm_sec),
    .alarm_min  (alarm_min),
    .alarm_hour (alarm_hour),
    .ringing    (ringing),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       us, um, uh, en, dis, tk;
    logic [5:0] cs;
    logic       exp_ring;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string pfx, input logic [5:0] es, input logic [5:0] em,
                           input logic [4:0] eh, input logic er, input logic [1:0] est);
    check({pfx, ".sec"},   32'(alarm_sec),  32'(es));
    check({pfx, ".min"},   32'(alarm_min),  32'(em));
    check({pfx, ".hour"},  32'(alarm_hour), 32'(eh));
    check({pfx, ".ring"},  32'(ringing),    32'(er));
    check({pfx, ".state"}, 32'(fsm_state),  32'(est));
    $display("[TB] %s: alarm %0d:%0d:%0d ringing=%0d state=%0d",
             pfx, alarm_hour, alarm_min, alarm_sec, ringing, fsm_state);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic us, input logic um, input logic uh,
                      input logic en, input logic dis, input logic tk, input logic [5:0] cs,
                      input logic er, input logic [1:0] est);
    vecs[i].us = us; vecs[i].um = um; vecs[i].uh = uh;
    vecs[i].en = en; vecs[i].dis = dis; vecs[i].tk = tk;
    vecs[i].cs = cs; vecs[i].exp_ring = er; vecs[i].exp_state = est;
  endtask

  initial begin
    // Alarm is 07:30:05 for the whole table; cur is 07:30:cs
    //      i   us um uh en dis tk cs  ring state
    setv( 0, 0, 0, 0, 1, 0, 0, 4, 0, 1);  // IDLE -> ARMED, no match
    setv( 1, 0, 0, 0, 1, 0, 0, 5, 1, 2);  // match -> RING
    setv( 2, 1, 1, 1, 1, 0, 0, 5, 1, 2);  // edits locked out in RING
    setv( 3, 0, 0, 0, 1, 1, 0, 5, 0, 3);  // dismiss -> HOLDOFF
    setv( 4, 0, 0, 0, 1, 0, 0, 5, 0, 3);  // still matching: hold
    setv( 5, 0, 0, 0, 1, 0, 0, 6, 0, 1);  // match gone -> ARMED
    setv( 6, 0, 0, 0, 1, 0, 0, 5, 1, 2);  // retrigger
    setv( 7, 0, 0, 0, 1, 0, 1, 5, 1, 2);  // tick 1
    setv( 8, 0, 0, 0, 1, 0, 1, 5, 1, 2);  // tick 2
    setv( 9, 0, 0, 0, 1, 0, 1, 5, 0, 3);  // tick 3: timeout
    setv(10, 0, 0, 0, 1, 0, 1, 5, 0, 3);  // no retrigger while matching
    setv(11, 0, 0, 0, 1, 0, 0, 5, 0, 3);
    setv(12, 0, 0, 0, 1, 0, 0, 4, 0, 1);  // -> ARMED
    setv(13, 0, 0, 0, 1, 0, 0, 5, 1, 2);  // RING
    setv(14, 0, 0, 0, 0, 0, 0, 5, 0, 0);  // disable -> IDLE
    setv(15, 0, 0, 0, 0, 0, 0, 5, 0, 0);  // disabled + match: silent
    setv(16, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    setv(17, 0, 0, 0, 1, 1, 0, 5, 0, 1);  // dismiss ignored outside RING
    setv(18, 0, 0, 0, 1, 0, 1, 5, 1, 2);  // entry tick not counted
    setv(19, 0, 0, 0, 1, 0, 1, 5, 1, 2);  // tick 1
    setv(20, 0, 0, 0, 1, 0, 1, 5, 1, 2);  // tick 2
    setv(21, 0, 0, 0, 1, 1, 1, 5, 0, 3);  // dismiss + final tick together
    setv(22, 0, 0, 0, 1, 0, 0, 6, 0, 1);
    setv(23, 0, 0, 0, 1, 1, 0, 6, 0, 1);  // dismiss in ARMED ignored

    reset = 1'b1;
    {upsec, upmin, uphour, alarm_en, dismiss, tick} = '0;
    cur_sec = 6'd0; cur_min = 6'd0; cur_hour = 5'd0;
    repeat (2) step();
    check_all("reset", 6'd0, 6'd0, 5'd0, 1'b0, 2'd0);
    reset = 1'b0;

    // Seconds wrap without carrying into minutes
    upsec = 1'b1;
    repeat (59) step();
    check("sec59", 32'(alarm_sec), 32'd59);
    step();
    upsec = 1'b0;
    check("sec_wrap", 32'(alarm_sec), 32'd0);
    check("sec_wrap_min", 32'(alarm_min), 32'd0);

    uphour = 1'b1;
    repeat (23) step();
    check("hour23", 32'(alarm_hour), 32'd23);
    step();
    uphour = 1'b0;
    check("hour_wrap", 32'(alarm_hour), 32'd0);

    {upsec, upmin, uphour} = 3'b111;
    step();
    {upsec, upmin, uphour} = 3'b000;
    check_all("simul", 6'd1, 6'd1, 5'd1, 1'b0, 2'd0);

    // Program 07:30:05 from 01:01:01
    for (int i = 0; i < 29; i++) begin
      upsec  = (i < 4);
      upmin  = 1'b1;
      uphour = (i < 6);
      step();
    end
    {upsec, upmin, uphour} = 3'b000;
    check_all("prog", 6'd5, 6'd30, 5'd7, 1'b0, 2'd0);

    cur_min = 6'd30; cur_hour = 5'd7;
    for (int i = 0; i < 24; i++) begin
      upsec = vecs[i].us; upmin = vecs[i].um; uphour = vecs[i].uh;
      alarm_en = vecs[i].en; dismiss = vecs[i].dis; tick = vecs[i].tk;
      cur_sec = vecs[i].cs;
      step();
      check_all($sformatf("vec%0d", i), 6'd5, 6'd30, 5'd7, vecs[i].exp_ring, vecs[i].exp_state);
    end
    {upsec, upmin, uphour, dismiss, tick} = '0;

    // Async reset in the middle of a ringing cycle
    cur_sec = 6'd5;
    step();
    check("pre_reset_ring", 32'(ringing), 32'd1);
    #2 reset = 1'b1;
    #1 check_all("async_reset", 6'd0, 6'd0, 5'd0, 1'b0, 2'd0);
    #1 reset = 1'b0;

    // Edit-induced trigger: alarm 00:00:00, cur 00:00:01
    cur_sec = 6'd1; cur_min = 6'd0; cur_hour = 5'd0; alarm_en = 1'b1;
    step();
    check_all("edit_armed", 6'd0, 6'd0, 5'd0, 1'b0, 2'd1);
    upsec = 1'b1;
    step();
    upsec = 1'b0;
    check_all("edit_upd", 6'd1, 6'd0, 5'd0, 1'b0, 2'd1);
    step();
    check_all("edit_ring", 6'd1, 6'd0, 5'd0, 1'b1, 2'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
